// File: rtl/touch_scan_pkg.sv
// Shared constants, scan-state enum and ADC command table for the touch ADC scanner.
package touch_scan_pkg;

  localparam int unsigned FRAME_LEN  = 24;
  localparam int unsigned CMD_BITS   = 8;
  localparam int unsigned DATA_START = 9;

  // Pen-present threshold on averaged Z1, expressed at 12-bit resolution
  localparam logic [11:0] PEN_THRESH = 12'h040;

  localparam logic [7:0] CMD_X  = 8'hD3;
  localparam logic [7:0] CMD_Y  = 8'h93;
  localparam logic [7:0] CMD_Z1 = 8'hB3;
  localparam logic [7:0] CMD_Z2 = 8'hC3;

  typedef enum logic [1:0] {StIdle, StGap, StShift, StAccum} scan_state_e;

  // Command byte for a channel; bit 3 (MODE) selects 8-bit conversions
  function automatic logic [7:0] cmd_byte(input logic [1:0] ch, input logic mode8);
    logic [7:0] c;
    case (ch)
      2'd0:    c = CMD_X;
      2'd1:    c = CMD_Y;
      2'd2:    c = CMD_Z1;
      default: c = CMD_Z2;
    endcase
    c[3] = c[3] | mode8;
    return c;
  endfunction

endpackage

// File: rtl/touch_adc_scanner_if.sv
// SPI pin bundle between the scanner (master) and an ADS7843-class ADC (slave).
interface touch_adc_scanner_if;
  logic spi_clk;
  logic spi_dout;
  logic spi_csb;
  logic spi_busy;
  logic spi_din;

  modport master (output spi_clk, spi_dout, spi_csb, input spi_busy, spi_din);
  modport slave  (input spi_clk, spi_dout, spi_csb, output spi_busy, spi_din);
endinterface

// File: rtl/touch_spi_frame.sv
// One 24-clock SPI frame: clock divider, DCLK generation, command shift-out and data capture.
module touch_spi_frame
  import touch_scan_pkg::*;
#(
  parameter int unsigned CLK_DIV = 25,
  parameter int unsigned RES     = 12
) (
  input  logic                cclk,
  input  logic                rst,
  input  logic                start,
  input  logic [7:0]          cmd,
  touch_adc_scanner_if.master spi,
  output logic                done,
  output logic [RES-1:0]      sample,
  output logic                busy_hit
);

  localparam int unsigned DivW = $clog2(CLK_DIV);

  logic [DivW-1:0] div_q;
  logic [5:0]      half_q;
  logic            active_q;
  logic            sclk_q;
  logic [7:0]      cmd_q;
  logic [RES-1:0]  data_q;

  logic       tick;
  logic       rise;
  logic       fall;
  logic [4:0] bit_k;
  logic       cap;

  // half_q counts DCLK half-periods; even halves end in a rising edge, odd in a falling edge
  assign tick  = active_q && (div_q == DivW'(CLK_DIV - 1));
  assign rise  = tick && !half_q[0];
  assign fall  = tick && half_q[0];
  assign bit_k = half_q[5:1];
  assign cap   = rise && (bit_k >= 5'(DATA_START)) && (bit_k < 5'(DATA_START + RES));
  assign done  = fall && (half_q == 6'(2 * FRAME_LEN - 1));

  assign busy_hit     = cap && spi.spi_busy;
  assign sample       = data_q;
  assign spi.spi_clk  = sclk_q;
  assign spi.spi_csb  = !active_q;
  // Command register shifts out to zero, so DIN idles low after bit 7
  assign spi.spi_dout = cmd_q[7];

  // Frame sequencing, DCLK toggling, command shift and MSB-first data capture
  always_ff @(posedge cclk or posedge rst) begin
    if (rst) begin
      div_q    <= '0;
      half_q   <= '0;
      active_q <= 1'b0;
      sclk_q   <= 1'b0;
      cmd_q    <= '0;
      data_q   <= '0;
    end else if (start && !active_q) begin
      div_q    <= '0;
      half_q   <= '0;
      active_q <= 1'b1;
      sclk_q   <= 1'b0;
      cmd_q    <= cmd;
      data_q   <= '0;
    end else if (active_q) begin
      if (tick) begin
        div_q  <= '0;
        half_q <= half_q + 6'd1;
        sclk_q <= !half_q[0];
        if (fall) cmd_q <= {cmd_q[6:0], 1'b0};
        if (cap) data_q <= {data_q[RES-2:0], spi.spi_din};
        if (done) active_q <= 1'b0;
      end else begin
        div_q <= div_q + DivW'(1);
      end
    end
  end

endmodule

// File: rtl/touch_adc_scanner.sv
// Free-running round-robin touch ADC scanner with per-channel averaging.
// Optional pen gating of X/Y results: define TOUCH_SCAN_PEN_DETECT_EN.
module touch_adc_scanner
  import touch_scan_pkg::*;
#(
  parameter int unsigned CLK_DIV  = 25,
  parameter int unsigned NUM_CH   = 3,
  parameter int unsigned AVG_LOG2 = 3,
  parameter int unsigned RES      = 12
) (
  input  logic                    cclk,
  input  logic                    rst,
  input  logic                    en,
  touch_adc_scanner_if.master     spi,
  output logic [NUM_CH*RES-1:0]   result,
  output logic                    result_valid,
  output logic [1:0]              ch_idx,
  output logic                    busy_err
);

  localparam int unsigned SW   = RES + AVG_LOG2;
  localparam int unsigned GapW = $clog2(2 * CLK_DIV);

  scan_state_e            state_q, state_d;
  logic [GapW-1:0]        gap_q, gap_d;
  logic [4:0]             conv_q, conv_d;
  logic [1:0]             ch_q, ch_d;
  logic [SW-1:0]          sum_q, sum_d;
  logic [NUM_CH*RES-1:0]  res_q, res_d;
  logic                   valid_q, valid_d;
  logic                   err_q, err_d;
  logic                   abort_q, abort_d;

  logic                   start;
  logic                   done;
  logic                   busy_hit;
  logic [RES-1:0]         sample;
  logic [SW-1:0]          acc;
  logic [RES-1:0]         avg;
  logic                   last_conv;
  logic                   wrap;

`ifdef TOUCH_SCAN_PEN_DETECT_EN
  localparam bit PenEn = (NUM_CH >= 3);
  localparam logic [RES-1:0] PenThr = (RES == 8) ? RES'(PEN_THRESH >> 4) : RES'(PEN_THRESH);
  // X/Y are staged until the scan's Z1 confirms a pen is present
  logic [2*RES-1:0] xy_q, xy_d;
  logic [RES-1:0]   z1_q, z1_d, z1_now;
`endif

  touch_spi_frame #(
    .CLK_DIV (CLK_DIV),
    .RES     (RES)
  ) u_frame (
    .cclk     (cclk),
    .rst      (rst),
    .start    (start),
    .cmd      (cmd_byte(ch_q, RES == 8)),
    .spi      (spi),
    .done     (done),
    .sample   (sample),
    .busy_hit (busy_hit)
  );

  assign acc       = sum_q + SW'(sample);
  assign avg       = RES'(acc >> AVG_LOG2);
  assign last_conv = (conv_q == 5'((1 << AVG_LOG2) - 1));
  assign wrap      = (ch_q == 2'(NUM_CH - 1));

  assign result       = res_q;
  assign result_valid = valid_q;
  assign ch_idx       = ch_q;
  assign busy_err     = err_q;

  // Scan FSM next-state, averaging and result update
  always_comb begin
    state_d = state_q;
    gap_d   = gap_q;
    conv_d  = conv_q;
    ch_d    = ch_q;
    sum_d   = sum_q;
    res_d   = res_q;
    valid_d = 1'b0;
    err_d   = err_q | busy_hit;
    abort_d = abort_q;
    start   = 1'b0;
`ifdef TOUCH_SCAN_PEN_DETECT_EN
    xy_d    = xy_q;
    z1_d    = z1_q;
    z1_now  = z1_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (en) begin
          state_d = StGap;
          gap_d   = '0;
          err_d   = 1'b0;
        end
      end
      StGap: begin
        if (!en) begin
          state_d = StIdle;
          sum_d   = '0;
          conv_d  = '0;
          ch_d    = '0;
        end else if (gap_q == GapW'(2 * CLK_DIV - 1)) begin
          state_d = StShift;
          start   = 1'b1;
        end else begin
          gap_d = gap_q + GapW'(1);
        end
      end
      StShift: begin
        // Remember a drop of en so the frame in flight is discarded
        if (!en) abort_d = 1'b1;
        if (done) state_d = StAccum;
      end
      StAccum: begin
        gap_d   = '0;
        abort_d = 1'b0;
        if (abort_q || !en) begin
          state_d = StIdle;
          sum_d   = '0;
          conv_d  = '0;
          ch_d    = '0;
        end else begin
          state_d = StGap;
          if (last_conv) begin
            sum_d  = '0;
            conv_d = '0;
            ch_d   = wrap ? 2'd0 : ch_q + 2'd1;
`ifdef TOUCH_SCAN_PEN_DETECT_EN
            if (PenEn && ch_q < 2'd2) xy_d[ch_q[0]*RES +: RES] = avg;
            else res_d[ch_q*RES +: RES] = avg;
            if (ch_q == 2'd2) z1_d = avg;
            if (wrap) begin
              z1_now = (ch_q == 2'd2) ? avg : z1_q;
              if (!PenEn || z1_now >= PenThr) begin
                valid_d = 1'b1;
                if (PenEn) res_d[2*RES-1:0] = xy_d;
              end
            end
`else
            res_d[ch_q*RES +: RES] = avg;
            if (wrap) valid_d = 1'b1;
`endif
          end else begin
            sum_d  = acc;
            conv_d = conv_q + 5'd1;
          end
        end
      end
    endcase
  end

  // Scan state, counters and published results
  always_ff @(posedge cclk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      gap_q   <= '0;
      conv_q  <= '0;
      ch_q    <= '0;
      sum_q   <= '0;
      res_q   <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      abort_q <= 1'b0;
`ifdef TOUCH_SCAN_PEN_DETECT_EN
      xy_q    <= '0;
      z1_q    <= '0;
`endif
    end else begin
      state_q <= state_d;
      gap_q   <= gap_d;
      conv_q  <= conv_d;
      ch_q    <= ch_d;
      sum_q   <= sum_d;
      res_q   <= res_d;
      valid_q <= valid_d;
      err_q   <= err_d;
      abort_q <= abort_d;
`ifdef TOUCH_SCAN_PEN_DETECT_EN
      xy_q    <= xy_d;
      z1_q    <= z1_d;
`endif
    end
  end

endmodule

// File: tb/tb_touch_adc_scanner.sv
// Directed bench for touch_adc_scanner with a behavioural ADS7843 model.
module tb_touch_adc_scanner;
  import touch_scan_pkg::*;

  localparam int unsigned CD  = 4;
  localparam int unsigned NCH = 3;
  localparam int unsigned AVG = 3;
  localparam int unsigned RB  = 12;

  logic              cclk = 1'b0;
  logic              rst;
  logic              en;
  logic [NCH*RB-1:0] result;
  logic              result_valid;
  logic [1:0]        ch_idx;
  logic              busy_err;

  touch_adc_scanner_if spi ();

  touch_adc_scanner #(
    .CLK_DIV  (CD),
    .NUM_CH   (NCH),
    .AVG_LOG2 (AVG),
    .RES      (RB)
  ) dut (
    .cclk         (cclk),
    .rst          (rst),
    .en           (en),
    .spi          (spi),
    .result       (result),
    .result_valid (result_valid),
    .ch_idx       (ch_idx),
    .busy_err     (busy_err)
  );

  always #5 cclk = ~cclk;

  // ADC model: decodes the command, shifts data after falling DCLK edges
  logic [11:0] x_val, y_val, z1_val, z2_val;
  logic        x_alt, busy_inject;
  logic        din_m = 1'b0, busy_m = 1'b0;
  logic        cs_prev = 1'b1, ck_prev = 1'b0;
  logic        x_par = 1'b0;
  logic [7:0]  m_cmd = 8'h00;
  logic [11:0] m_val = 12'h000;
  int          m_k = 0;

  assign spi.spi_din  = din_m;
  assign spi.spi_busy = busy_m;

  always @(spi.spi_clk or spi.spi_csb) begin
    if (cs_prev && spi.spi_csb === 1'b0) begin
      m_k = 0; m_cmd = 8'h00; din_m = 1'b0; busy_m = 1'b0;
    end else if (!ck_prev && spi.spi_clk === 1'b1) begin
      if (m_k < 8) m_cmd = {m_cmd[6:0], spi.spi_dout};
      if (m_k == 7) begin
        case (m_cmd[6:4])
          3'b101: begin m_val = x_alt ? (x_par ? 12'h103 : 12'h100) : x_val; x_par = !x_par; end
          3'b001: m_val = y_val;
          3'b011: m_val = z1_val;
          default: m_val = z2_val;
        endcase
      end
      m_k = m_k + 1;
    end else if (ck_prev && spi.spi_clk === 1'b0) begin
      din_m  = (m_k >= 9 && m_k < 21) ? m_val[20 - m_k] : 1'b0;
      busy_m = busy_inject && (m_k == 10);
    end
    cs_prev = (spi.spi_csb !== 1'b0);
    ck_prev = (spi.spi_clk === 1'b1);
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Drop en and wait until the scanner has parked in IDLE
  task automatic go_idle();
    int hi = 0;
    en = 1'b0;
    for (int i = 0; i < 600 && hi < 20; i++) begin
      @(negedge cclk);
      hi = spi.spi_csb ? hi + 1 : 0;
    end
    check("idle_reached", 64'(hi >= 20), 64'd1);
  endtask

  // Raise en and count frames until the first result_valid
  task automatic run_to_valid(output int falls, output logic got);
    logic prev = 1'b1;
    falls = 0;
    got   = 1'b0;
    en    = 1'b1;
    for (int i = 0; i < 6000 && !got; i++) begin
      @(negedge cclk);
      if (prev && !spi.spi_csb) falls++;
      prev = spi.spi_csb;
      if (result_valid) got = 1'b1;
    end
  endtask

  typedef struct {
    logic [11:0] x, y, z1;
    logic        alt;
    logic [35:0] exp;
  } vec_t;

  vec_t vecs[4];

  initial begin
    int   falls, rises, lowlen, highlen, first, quiet, fin_len, n;
    logic got, prev_ck, prev_cs, dropped, saw_valid, tail_or;
    logic [7:0] cmd_seen;

    vecs[0] = '{x: 12'h3A5, y: 12'h1F0, z1: 12'h200, alt: 1'b0,
                exp: {12'h200, 12'h1F0, 12'h3A5}};
    vecs[1] = '{x: 12'h000, y: 12'h1F0, z1: 12'h200, alt: 1'b1,
                exp: {12'h200, 12'h1F0, 12'h101}};
    vecs[2] = '{x: 12'hFFF, y: 12'h000, z1: 12'h040, alt: 1'b0,
                exp: {12'h040, 12'h000, 12'hFFF}};
    vecs[3] = '{x: 12'h800, y: 12'h7FF, z1: 12'h555, alt: 1'b0,
                exp: {12'h555, 12'h7FF, 12'h800}};

    rst = 1'b1; en = 1'b0; busy_inject = 1'b0; x_alt = 1'b0;
    x_val = 12'h3A5; y_val = 12'h1F0; z1_val = 12'h200; z2_val = 12'h0AA;
    repeat (3) @(negedge cclk);
    check("rst_csb", 64'(spi.spi_csb), 64'd1);
    check("rst_sclk", 64'(spi.spi_clk), 64'd0);
    check("rst_dout", 64'(spi.spi_dout), 64'd0);
    check("rst_result", 64'(result), 64'd0);
    check("rst_valid", 64'(result_valid), 64'd0);
    check("rst_ch_idx", 64'(ch_idx), 64'd0);
    check("rst_busy_err", 64'(busy_err), 64'd0);
    rst = 1'b0;
    @(negedge cclk);

    // Bit-level frame shape with CLK_DIV=4
    en = 1'b1;
    n  = 0;
    while (spi.spi_csb && n < 200) begin @(negedge cclk); n++; end
    check("csb_fell", 64'(spi.spi_csb), 64'd0);
    lowlen = 0; rises = 0; first = -1; cmd_seen = 8'h00; tail_or = 1'b0; prev_ck = 1'b0;
    while (!spi.spi_csb && lowlen < 400) begin
      lowlen++;
      if (spi.spi_clk && !prev_ck) begin
        if (first < 0) first = lowlen - 1;
        if (rises < 8) cmd_seen = {cmd_seen[6:0], spi.spi_dout};
        else tail_or = tail_or | spi.spi_dout;
        rises++;
      end
      prev_ck = spi.spi_clk;
      @(negedge cclk);
    end
    check("frame_low_len", 64'(lowlen), 64'(48 * CD));
    check("frame_rises", 64'(rises), 64'd24);
    check("first_rise_ofs", 64'(first), 64'(CD));
    check("cmd_bits", 64'(cmd_seen), 64'hD3);
    check("dout_tail_zero", 64'(tail_or), 64'd0);
    check("sclk_low_at_csb_rise", 64'(spi.spi_clk), 64'd0);
    highlen = 0;
    while (spi.spi_csb && highlen < 100) begin highlen++; @(negedge cclk); end
    // Between frames csb stays high for the ACCUM cycle plus the 2*CLK_DIV gap
    check("csb_high_gap", 64'(highlen), 64'(2 * CD + 1));
    go_idle();

    for (int v = 0; v < 4; v++) begin
      x_val = vecs[v].x; y_val = vecs[v].y; z1_val = vecs[v].z1; x_alt = vecs[v].alt;
      run_to_valid(falls, got);
      check($sformatf("v%0d_valid_seen", v), 64'(got), 64'd1);
      check($sformatf("v%0d_frames", v), 64'(falls), 64'd24);
      check($sformatf("v%0d_result", v), 64'(result), 64'(vecs[v].exp));
      check($sformatf("v%0d_ch_wrap", v), 64'(ch_idx), 64'd0);
      @(negedge cclk);
      check($sformatf("v%0d_valid_pulse", v), 64'(result_valid), 64'd0);
      go_idle();
    end

    // Drop en at k=12 of the fifth X frame
    en = 1'b1; falls = 0; rises = 0; prev_cs = 1'b1; prev_ck = 1'b0; dropped = 1'b0;
    saw_valid = 1'b0; lowlen = 0; quiet = 0; fin_len = 0;
    for (int i = 0; i < 2000 && !(dropped && quiet >= 40); i++) begin
      @(negedge cclk);
      if (result_valid) saw_valid = 1'b1;
      if (prev_cs && !spi.spi_csb) begin falls++; rises = 0; lowlen = 0; end
      if (!spi.spi_csb) lowlen++;
      if (!prev_ck && spi.spi_clk && !spi.spi_csb) rises++;
      if (dropped && !prev_cs && spi.spi_csb) fin_len = lowlen;
      if (falls == 5 && rises == 13 && !dropped) begin en = 1'b0; dropped = 1'b1; end
      quiet   = (dropped && spi.spi_csb) ? quiet + 1 : 0;
      prev_cs = spi.spi_csb;
      prev_ck = spi.spi_clk;
    end
    check("drop_applied", 64'(dropped), 64'd1);
    check("drop_frame_finished", 64'(fin_len), 64'(48 * CD));
    check("drop_no_new_frame", 64'(falls), 64'd5);
    check("drop_no_valid", 64'(saw_valid), 64'd0);
    run_to_valid(falls, got);
    check("restart_valid_seen", 64'(got), 64'd1);
    check("restart_frames", 64'(falls), 64'd24);
    check("restart_result", 64'(result), 64'(vecs[3].exp));

    // busy_err stickiness, then asynchronous reset mid-SHIFT
    go_idle();
    busy_inject = 1'b1;
    en = 1'b1;
    n  = 0;
    while (spi.spi_csb && n < 200) begin @(negedge cclk); n++; end
    repeat (100) @(negedge cclk);
    check("busy_err_set", 64'(busy_err), 64'd1);
    busy_inject = 1'b0;
    repeat (250) @(negedge cclk);
    check("busy_err_sticky", 64'(busy_err), 64'd1);
    n = 0;
    while (spi.spi_csb && n < 200) begin @(negedge cclk); n++; end
    repeat (30) @(negedge cclk);
    check("pre_rst_in_shift", 64'(spi.spi_csb), 64'd0);
    #2 rst = 1'b1;
    #1;
    check("arst_csb", 64'(spi.spi_csb), 64'd1);
    check("arst_sclk", 64'(spi.spi_clk), 64'd0);
    check("arst_dout", 64'(spi.spi_dout), 64'd0);
    check("arst_result", 64'(result), 64'd0);
    check("arst_valid", 64'(result_valid), 64'd0);
    check("arst_ch_idx", 64'(ch_idx), 64'd0);
    check("arst_busy_err", 64'(busy_err), 64'd0);
    en = 1'b0;
    repeat (3) @(negedge cclk);
    rst = 1'b0;
    repeat (20) @(negedge cclk);
    check("post_rst_idle", 64'(spi.spi_csb), 64'd1);

`ifdef TOUCH_SCAN_PEN_DETECT_EN
    x_alt = 1'b0;
    x_val = 12'h111; y_val = 12'h222; z1_val = 12'h300;
    run_to_valid(falls, got);
    check("pen_first_valid", 64'(got), 64'd1);
    check("pen_first_xy", 64'(result[2*RB-1:0]), 64'h222111);
    go_idle();
    x_val = 12'hAAA; y_val = 12'hBBB; z1_val = 12'h020;
    run_to_valid(falls, got);
    check("pen_up_no_valid", 64'(got), 64'd0);
    check("pen_up_xy_hold", 64'(result[2*RB-1:0]), 64'h222111);
    go_idle();
    z1_val = 12'h300;
    run_to_valid(falls, got);
    check("pen_down_valid", 64'(got), 64'd1);
    check("pen_down_xy", 64'(result[2*RB-1:0]), 64'hBBBAAA);
    go_idle();
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
